// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device-side DB15 joystick shift-register responder.
// The two player words are latched while the host holds the load strobe low.
// After that, one bit is shifted out per rising edge of the host shift clock
// on an active-low data line. The host strobes are asynchronous to clk and
// are oversampled through flop synchronizers.
module joy_db15_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        joy_clk_in,
    input  logic        joy_load_in,
    output logic        joy_data_out,
    output logic        frame_done,
    output logic        busy
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] BIT_PENULT = BCW'(FRAME_BITS - 1);
    localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOADED   = 2'd1,
        ST_SHIFTING = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]  load_sync_q, load_sync_d;
    logic                    clk_hist_q, clk_hist_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]          to_cnt_q, to_cnt_d;
    logic                    frame_done_q, frame_done_d;

    logic                    sync_clk;
    logic                    clk_rise;
    logic                    load_act;
    logic [FRAME_BITS-1:0]   load_word;

    assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
    assign clk_rise  = sync_clk & ~clk_hist_q;
    assign load_act  = ~load_sync_q[SYNC_STAGES-1];
    // Line is active-low, so a pressed (1) button is driven as 0; player 1 first.
    assign load_word = FRAME_BITS'(~{joystick2, joystick1});

    // Synchronizer chains and the edge-detect history flop.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], joy_clk_in};
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], joy_load_in};
        clk_hist_d  = sync_clk;
    end

    // Frame FSM: load, shift, terminal count and inactivity timeout.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                if (load_act) begin
                    state_d = ST_LOADED;
                    sr_d    = load_word;
                end
            end

            ST_LOADED: begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                // Host clock edges here are deliberately ignored.
                if (load_act) begin
                    sr_d = load_word;
                end else begin
                    state_d = ST_SHIFTING;
                end
            end

            ST_SHIFTING: begin
                if (load_act) begin
                    // Mid-frame reload: restart the frame, no completion pulse.
                    state_d   = ST_LOADED;
                    sr_d      = load_word;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end else if (clk_rise) begin
                    sr_d      = {1'b1, sr_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == BIT_PENULT) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; synchronizers reset to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            clk_sync_q   <= '1;
            load_sync_q  <= '1;
            clk_hist_q   <= 1'b1;
            sr_q         <= '1;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            load_sync_q  <= load_sync_d;
            clk_hist_q   <= clk_hist_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign joy_data_out = (state_q == ST_IDLE) ? 1'b1 : sr_q[0];
    assign busy         = (state_q == ST_LOADED) || (state_q == ST_SHIFTING);
    assign frame_done   = frame_done_q;

endmodule
